mb_io_slave_regs: RTL and testbench
===================================

// Module: mb_io_slave_regs
// PURPOSE
//  Microblaze IO Bus slave: a bank of NUM_REGS 32-bit read/write control registers, placed directly downstream of the IO bus master.
//  Decodes the bus strobes and inserts programmable wait states. Returns a single-cycle IO_Ready pulse.
//  Register contents and per-register write pulses feed the peripheral logic behind it.
// PARAMETERS
//  BASE_ADDR    32'hC000_0000  byte base address of register 0; aligned to 4*NUM_REGS
//  NUM_REGS     8              register count; power of 2, 2..64
//  WAIT_STATES  2              cycles between capture and IO_Ready; 0..15
// PORTS
//  clk              in   1            bus clock; all logic on rising edge
//  reset            in   1            asynchronous reset, active-low (asserted at 0)
//  IO_Addr_Strobe   in   1            access request
//  IO_Read_Strobe   in   1            read qualifier
//  IO_Write_Strobe  in   1            write qualifier
//  IO_Address       in   32           byte address
//  IO_Byte_Enable   in   4            lane enables; bit i = IO_Write_Data[8i+7:8i]
//  IO_Write_Data    in   32           write data, lane-replicated by master
//  IO_Ready         out  1            one-cycle completion pulse
//  IO_Read_Data     out  32           read data, valid only while IO_Ready=1
//  reg_q            out  32*NUM_REGS  register contents; reg k at [32k+31:32k]
//  reg_wr           out  NUM_REGS     one-cycle pulse: reg k written this cycle
// BEHAVIOUR
//  Reset (reset=0, async): FSM->IDLE; IO_Ready=0; IO_Read_Data=0; reg_q=0; reg_wr=0; counter=0; latched request cleared.
//    Transaction in flight is abandoned; no IO_Ready is produced for it.
//  Decode: hit = (IO_Address & ~(4*NUM_REGS-1)) == BASE_ADDR; index = IO_Address[log2(NUM_REGS)+1:2]; addr[1:0] ignored.
//  FSM states: IDLE, WAIT, ACK, HOLD.
//   IDLE: when IO_Addr_Strobe=1, latch address, enables, data, direction, hit.
//     Then load counter=WAIT_STATES; go WAIT, or go ACK when WAIT_STATES=0.
//   WAIT: counter decrements each cycle; at counter==1 go ACK.
//     Latency: strobe-sampled edge to IO_Ready high = WAIT_STATES+1 cycles.
//   ACK: IO_Ready=1 for exactly this cycle.
//     Write hit: merge enabled lanes into reg_q[index] at this edge; reg_wr[index]=1 this cycle.
//     Read hit: IO_Read_Data=reg_q[index], full word; byte enables ignored on reads.
//     Go HOLD.
//   HOLD: stay while IO_Addr_Strobe=1; go IDLE when it is 0.
//     Accepts both a held strobe (released after IO_Ready) and a single-cycle strobe.
//     Min back-to-back spacing = WAIT_STATES+3 cycles.
//  IO_Ready falls between accesses, so every access gives the master a fresh rising edge.
//  Outside ACK: IO_Ready=0 and IO_Read_Data=0.
//  Strobes are ignored outside IDLE; no queuing.
//  Miss, or Read/Write strobes both 1 or both 0:
//    Access is still acknowledged on the normal timing, so the bus never hangs.
//    No register changes; reg_wr stays 0; read data = 0.
//  Write with IO_Byte_Enable=0: acknowledged; no lane changes, but reg_wr still pulses.
//  Register outputs change only at the ACK edge.
// CONFIGURATION
//  MB_IO_SLAVE_ERR_EN defined:
//    Adds output port io_err (1 bit, reset 0), pulsed high together with IO_Ready on a decode miss or an illegal strobe combination.
//    Read data for those accesses = 32'hDEAD_BEEF.
//  Undefined: no io_err port; error accesses read 32'h0000_0000. All other behaviour is identical.
// TESTING
//  Reset released, read BASE+0x0/0x1C -> 0x0000_0000; IO_Ready high exactly 3 cycles after strobe sampled (WAIT_STATES=2).
//  Write BASE+0x4 BE=1111 data 0x1234_5678; write BE=0010 data 0xABAB_ABAB
//    -> reg 1 reads 0x1234_AB78; reg_wr[1] pulses once per write.
//  Write BASE+0x20 (miss) data 0xFFFF_FFFF -> acked, all regs unchanged.
//    Read there -> 0xDEAD_BEEF and io_err=1 with ERR_EN, 0x0 without.
//  Back-to-back held-strobe writes to regs 0..7 (value = 0x11*k) -> each acked once; readback matches; no double writes.
//  Assert reset=0 during WAIT of a write to reg 2 -> IO_Ready never pulses; reg 2=0.
//    After release, the next access completes normally.
//  WAIT_STATES=0 build: single-cycle strobe read -> IO_Ready next cycle; HOLD->IDLE with strobe already low.

Source files
------------

// File: rtl/mb_io_slave_regs.sv
// mb_io_slave_regs: MicroBlaze IO bus slave with a bank of NUM_REGS 32-bit
// read/write control registers. It decodes the bus strobes, waits WAIT_STATES
// cycles, then returns a single-cycle IO_Ready pulse. Register contents and
// per-register write pulses feed the peripheral logic behind the bank.
//
// Optional feature: define MB_IO_SLAVE_ERR_EN to add the io_err output. It
// pulses with IO_Ready on a decode miss or an illegal strobe combination, and
// such accesses then read 32'hDEAD_BEEF instead of 32'h0000_0000.
module mb_io_slave_regs #(
    parameter logic [31:0] BASE_ADDR   = 32'hC000_0000,
    parameter int          NUM_REGS    = 8,
    parameter int          WAIT_STATES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     IO_Addr_Strobe,
    input  logic                     IO_Read_Strobe,
    input  logic                     IO_Write_Strobe,
    input  logic [31:0]              IO_Address,
    input  logic [3:0]               IO_Byte_Enable,
    input  logic [31:0]              IO_Write_Data,
    output logic                     IO_Ready,
    output logic [31:0]              IO_Read_Data,
    output logic [32*NUM_REGS-1:0]   reg_q,
    output logic [NUM_REGS-1:0]      reg_wr
`ifdef MB_IO_SLAVE_ERR_EN
    ,
    output logic                     io_err
`endif
);

    localparam int          IDX_W     = $clog2(NUM_REGS);
    localparam logic [31:0] ADDR_MASK = ~(32'(4 * NUM_REGS) - 32'd1);
    localparam logic [3:0]  WS        = 4'(WAIT_STATES);

`ifdef MB_IO_SLAVE_ERR_EN
    localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;
`else
    localparam logic [31:0] ERR_RDATA = 32'h0000_0000;
`endif

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             wr_q, wr_d;     // legal write that hits the bank
    logic             rd_q, rd_d;     // legal read that hits the bank
    logic             err_q, err_d;   // miss or illegal strobe combination

    logic [31:0]      regs_q [NUM_REGS];

    logic             hit;
    logic [IDX_W-1:0] idx;
    logic             ack;

    // Replace only the byte lanes selected by the enables.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  lanes);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = lanes[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return res;
    endfunction

    assign hit = (IO_Address & ADDR_MASK) == BASE_ADDR;
    assign idx = IO_Address[IDX_W+1:2];
    assign ack = (state_q == S_ACK);

    // Next-state logic: capture the request in IDLE, count wait states, ack once, then hold until the strobe drops.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (IO_Addr_Strobe) begin
                    idx_d   = idx;
                    be_d    = IO_Byte_Enable;
                    wdata_d = IO_Write_Data;
                    wr_d    = hit && IO_Write_Strobe && !IO_Read_Strobe;
                    rd_d    = hit && IO_Read_Strobe && !IO_Write_Strobe;
                    err_d   = !(hit && (IO_Write_Strobe != IO_Read_Strobe));
                    cnt_d   = WS;
                    state_d = (WS == 4'd0) ? S_ACK : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK: begin
                state_d = S_HOLD;
            end
            default: begin
                if (!IO_Addr_Strobe) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // Control and latched-request state; reset abandons any access in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

    // Register bank: a write hit merges its enabled lanes at the edge that ends ACK.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= 32'd0;
            end
        end else if (ack && wr_q) begin
            regs_q[idx_q] <= merge_lanes(regs_q[idx_q], wdata_q, be_q);
        end
    end

    // Bus response: ready and read data are only non-zero during ACK.
    always_comb begin
        IO_Read_Data = 32'd0;
        if (ack) begin
            if (rd_q) begin
                IO_Read_Data = regs_q[idx_q];
            end else if (err_q) begin
                IO_Read_Data = ERR_RDATA;
            end
        end
    end

    assign IO_Ready = ack;

    // Per-register write pulse, raised for the ACK cycle of a write hit.
    always_comb begin
        reg_wr = '0;
        if (ack && wr_q) begin
            reg_wr[idx_q] = 1'b1;
        end
    end

`ifdef MB_IO_SLAVE_ERR_EN
    assign io_err = ack && err_q;
`endif

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg_out
        assign reg_q[32*k +: 32] = regs_q[k];
    end

endmodule

// File: tb/tb_mb_io_slave_regs.sv
// Testbench for mb_io_slave_regs: a WAIT_STATES=2 instance driven through a
// scoreboarded access task, plus a WAIT_STATES=0 instance for the fast path.
module tb_mb_io_slave_regs;

    localparam logic [31:0] BASE = 32'hC000_0000;
    localparam int          WS   = 2;
`ifdef MB_IO_SLAVE_ERR_EN
    localparam logic [31:0] ERRV = 32'hDEAD_BEEF;
`else
    localparam logic [31:0] ERRV = 32'h0000_0000;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         io_as, io_rs, io_ws;
    logic [31:0]  addr, wd;
    logic [3:0]   be;
    logic         rdy;
    logic [31:0]  rd;
    logic [255:0] regq;
    logic [7:0]   regwr;

    logic         z_as, z_rs, z_ws;
    logic [31:0]  z_addr, z_wd;
    logic [3:0]   z_be;
    logic         z_rdy;
    logic [31:0]  z_rd;
    logic [255:0] z_regq;
    logic [7:0]   z_regwr;

`ifdef MB_IO_SLAVE_ERR_EN
    logic err, z_err;
`endif

    mb_io_slave_regs #(.BASE_ADDR(BASE), .NUM_REGS(8), .WAIT_STATES(WS)) dut (
        .clk(clk), .reset(reset),
        .IO_Addr_Strobe(io_as), .IO_Read_Strobe(io_rs), .IO_Write_Strobe(io_ws),
        .IO_Address(addr), .IO_Byte_Enable(be), .IO_Write_Data(wd),
        .IO_Ready(rdy), .IO_Read_Data(rd), .reg_q(regq), .reg_wr(regwr)
`ifdef MB_IO_SLAVE_ERR_EN
        , .io_err(err)
`endif
    );

    mb_io_slave_regs #(.BASE_ADDR(BASE), .NUM_REGS(8), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset),
        .IO_Addr_Strobe(z_as), .IO_Read_Strobe(z_rs), .IO_Write_Strobe(z_ws),
        .IO_Address(z_addr), .IO_Byte_Enable(z_be), .IO_Write_Data(z_wd),
        .IO_Ready(z_rdy), .IO_Read_Data(z_rd), .reg_q(z_regq), .reg_wr(z_regwr)
`ifdef MB_IO_SLAVE_ERR_EN
        , .io_err(z_err)
`endif
    );

    typedef struct {
        logic        chk_rd;
        logic [31:0] rdata;
        logic [7:0]  wmask;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [8];
    int          wr_cnt [8];
    int          tests = 0;
    int          fails = 0;

    // Count reg_wr pulses per register to catch missing or doubled writes.
    always @(negedge clk) begin
        if (reset) begin
            for (int k = 0; k < 8; k++) begin
                if (regwr[k]) wr_cnt[k] = wr_cnt[k] + 1;
            end
        end
    end

    function automatic logic [31:0] lane_mask(input logic [3:0] b);
        return {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    endfunction

    function automatic logic [255:0] pack_model();
        logic [255:0] p;
        for (int k = 0; k < 8; k++) p[32*k +: 32] = model[k];
        return p;
    endfunction

    // One bus access: push the expectation, drive the strobes, then pop and compare at IO_Ready.
    task automatic access(input logic wr, input logic rdq, input logic [31:0] a,
                          input logic [3:0] b, input logic [31:0] d, input logic hold);
        exp_t e;
        logic hitv, lwr, lrd, seen;
        int   idx, lat;
        hitv = (a & ~32'h1F) == BASE;
        idx  = int'(a[4:2]);
        lwr  = hitv && wr && !rdq;
        lrd  = hitv && rdq && !wr;
        e.chk_rd = !lwr;
        e.rdata  = lrd ? model[idx] : ERRV;
        e.wmask  = lwr ? (8'b1 << idx) : 8'b0;
        e.err    = !(lwr || lrd);
        if (lwr) model[idx] = (model[idx] & ~lane_mask(b)) | (d & lane_mask(b));
        sb.push_back(e);
        @(negedge clk);
        io_as = 1'b1; io_rs = rdq; io_ws = wr; addr = a; be = b; wd = d;
        @(posedge clk);
        seen = 1'b0;
        lat  = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            if (!hold) begin io_as = 1'b0; io_rs = 1'b0; io_ws = 1'b0; end
            if (rdy) begin seen = 1'b1; lat = i; end
        end
        e = sb.pop_front();
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL timeout addr=%h: IO_Ready never seen, required within 20 cycles", a);
            io_as = 1'b0; io_rs = 1'b0; io_ws = 1'b0;
            return;
        end
        if (lat !== WS + 1) begin
            fails++;
            $display("FAIL latency addr=%h: got %0d cycles, required %0d", a, lat, WS + 1);
        end
        if (e.chk_rd) begin
            tests++;
            if (rd !== e.rdata) begin
                fails++;
                $display("FAIL rdata addr=%h: got %h, required %h", a, rd, e.rdata);
            end
        end
        tests++;
        if (regwr !== e.wmask) begin
            fails++;
            $display("FAIL reg_wr addr=%h: got %b, required %b", a, regwr, e.wmask);
        end
`ifdef MB_IO_SLAVE_ERR_EN
        tests++;
        if (err !== e.err) begin
            fails++;
            $display("FAIL io_err addr=%h: got %b, required %b", a, err, e.err);
        end
`endif
        @(negedge clk);
        tests++;
        if (rdy !== 1'b0 || rd !== 32'd0) begin
            fails++;
            $display("FAIL ready_pulse addr=%h: ready=%b data=%h after ack, required 0/0", a, rdy, rd);
        end
        io_as = 1'b0; io_rs = 1'b0; io_ws = 1'b0;
        tests++;
        if (regq !== pack_model()) begin
            fails++;
            $display("FAIL reg_q addr=%h: got %h, required %h", a, regq, pack_model());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        io_as = 1'b0; io_rs = 1'b0; io_ws = 1'b0; addr = 32'd0; be = 4'd0; wd = 32'd0;
        z_as = 1'b0; z_rs = 1'b0; z_ws = 1'b0; z_addr = 32'd0; z_be = 4'd0; z_wd = 32'd0;
        for (int k = 0; k < 8; k++) begin model[k] = 32'd0; wr_cnt[k] = 0; end
        repeat (3) @(negedge clk);
        tests++;
        if (rdy !== 1'b0 || rd !== 32'd0) begin
            fails++;
            $display("FAIL reset_bus: ready=%b data=%h, required 0/0", rdy, rd);
        end
        tests++;
        if (regq !== 256'd0 || regwr !== 8'd0) begin
            fails++;
            $display("FAIL reset_regs: reg_q=%h reg_wr=%b, required 0/0", regq, regwr);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_read_after_reset();
        access(1'b0, 1'b1, BASE + 32'h0,  4'hF, 32'd0, 1'b1);
        access(1'b0, 1'b1, BASE + 32'h1C, 4'hF, 32'd0, 1'b0);
    endtask

    task automatic test_byte_lanes();
        int c0;
        c0 = wr_cnt[1];
        access(1'b1, 1'b0, BASE + 32'h4, 4'b1111, 32'h1234_5678, 1'b1);
        access(1'b1, 1'b0, BASE + 32'h4, 4'b0010, 32'hABAB_ABAB, 1'b0);
        access(1'b0, 1'b1, BASE + 32'h7, 4'b0000, 32'd0, 1'b1);
        tests++;
        if (regq[63:32] !== 32'h1234_AB78) begin
            fails++;
            $display("FAIL lane_merge: reg1=%h, required 1234ab78", regq[63:32]);
        end
        access(1'b1, 1'b0, BASE + 32'h4, 4'b0000, 32'h0000_0000, 1'b1);
        tests++;
        if (wr_cnt[1] - c0 !== 3) begin
            fails++;
            $display("FAIL wr_pulses_reg1: got %0d, required 3", wr_cnt[1] - c0);
        end
    endtask

    task automatic test_miss();
        access(1'b1, 1'b0, BASE + 32'h20, 4'hF, 32'hFFFF_FFFF, 1'b1);
        access(1'b0, 1'b1, BASE + 32'h20, 4'hF, 32'd0, 1'b1);
        access(1'b1, 1'b0, 32'h4000_0004, 4'hF, 32'hFFFF_FFFF, 1'b0);
        access(1'b1, 1'b1, BASE + 32'h4, 4'hF, 32'h5555_5555, 1'b1);
        access(1'b0, 1'b0, BASE + 32'h4, 4'hF, 32'h5555_5555, 1'b0);
    endtask

    task automatic test_back_to_back();
        int c0 [8];
        for (int k = 0; k < 8; k++) c0[k] = wr_cnt[k];
        for (int k = 0; k < 8; k++)
            access(1'b1, 1'b0, BASE + 32'(4 * k), 4'hF, 32'h1111_1111 * 32'(k), 1'b1);
        for (int k = 0; k < 8; k++)
            access(1'b0, 1'b1, BASE + 32'(4 * k), 4'hF, 32'd0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            tests++;
            if (wr_cnt[k] - c0[k] !== 1) begin
                fails++;
                $display("FAIL b2b_pulses reg%0d: got %0d, required 1", k, wr_cnt[k] - c0[k]);
            end
        end
    endtask

    task automatic test_reset_abort();
        int seen, c2;
        c2 = wr_cnt[2];
        @(negedge clk);
        io_as = 1'b1; io_ws = 1'b1; io_rs = 1'b0; addr = BASE + 32'h8; be = 4'hF; wd = 32'hCAFE_F00D;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        io_as = 1'b0; io_ws = 1'b0;
        for (int k = 0; k < 8; k++) model[k] = 32'd0;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rdy) seen++;
        end
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rdy) seen++;
        end
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL abort_ready: IO_Ready seen %0d times, required 0", seen);
        end
        tests++;
        if (regq[95:64] !== 32'd0 || wr_cnt[2] !== c2) begin
            fails++;
            $display("FAIL abort_reg2: reg2=%h pulses=%0d, required 0/0", regq[95:64], wr_cnt[2] - c2);
        end
        access(1'b0, 1'b1, BASE + 32'h8, 4'hF, 32'd0, 1'b1);
        access(1'b1, 1'b0, BASE + 32'h8, 4'hF, 32'h0BAD_C0DE, 1'b0);
        access(1'b0, 1'b1, BASE + 32'h8, 4'hF, 32'd0, 1'b0);
    endtask

    task automatic test_ws0();
        @(negedge clk);
        z_as = 1'b1; z_ws = 1'b1; z_rs = 1'b0; z_addr = BASE + 32'hC; z_be = 4'hF; z_wd = 32'h5A5A_0FF0;
        @(negedge clk);
        tests++;
        if (z_rdy !== 1'b1 || z_regwr !== 8'b0000_1000) begin
            fails++;
            $display("FAIL ws0_write_ack: ready=%b reg_wr=%b, required 1/00001000", z_rdy, z_regwr);
        end
        z_as = 1'b0; z_ws = 1'b0;
        @(negedge clk);
        tests++;
        if (z_rdy !== 1'b0 || z_regq[127:96] !== 32'h5A5A_0FF0) begin
            fails++;
            $display("FAIL ws0_after_write: ready=%b reg3=%h, required 0/5a5a0ff0", z_rdy, z_regq[127:96]);
        end
        @(negedge clk);
        z_as = 1'b1; z_rs = 1'b1; z_addr = BASE + 32'hC;
        @(negedge clk);
        tests++;
        if (z_rdy !== 1'b1 || z_rd !== 32'h5A5A_0FF0) begin
            fails++;
            $display("FAIL ws0_read: ready=%b data=%h, required 1/5a5a0ff0", z_rdy, z_rd);
        end
        z_as = 1'b0; z_rs = 1'b0;
        @(negedge clk);
        tests++;
        if (z_rdy !== 1'b0 || z_rd !== 32'd0) begin
            fails++;
            $display("FAIL ws0_release: ready=%b data=%h, required 0/0", z_rdy, z_rd);
        end
    endtask

    initial begin
        test_reset();
        test_read_after_reset();
        test_byte_lanes();
        test_miss();
        test_back_to_back();
        test_reset_abort();
        test_ws0();
        tests++;
        if (sb.size() !== 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
